counter_sequence_checker: RTL and testbench

Monitor for the free-running 4-bit counter: samples the counter output on each qualified clock edge and confirms it advances by exactly +1 modulo 2^WIDTH. Acquires lock after a run of correct increments, then flags every sequence break with an error pulse and a saturating error count. Sits downstream of the counter in self-checking benches and in on-chip debug paths.

---
 rtl/counter_sequence_checker.sv | 114 +++++++++++
 tb/tb_counter_sequence_checker.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequence_checker.sv
// counter_sequence_checker
// Watches a free-running counter and confirms each qualified sample is the
// previous one plus one (mod 2^WIDTH). After LOCK_COUNT consecutive correct
// increments the monitor is LOCKED; from then on every break in the sequence
// produces a one-cycle error pulse and bumps a saturating error counter.
// A correct all-ones -> 0 step while LOCKED produces a one-cycle wrap pulse.
module counter_sequence_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] count_in,
  input  logic             err_clr,
  output logic             locked,
  output logic             error,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [3:0]       run;

  logic [WIDTH-1:0] prev_inc;
  logic [3:0]       run_inc;
  logic             match;
  logic             break_det;

  // Increment the error counter, sticking at all-ones instead of rolling over.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + ERR_W'(1);
  endfunction

  // prev + 1 kept in WIDTH bits so all-ones -> 0 counts as a correct step.
  assign prev_inc  = prev + WIDTH'(1);
  assign run_inc   = run + 4'd1;
  assign match     = (count_in == prev_inc);
  assign break_det = in_valid && (state == LOCKED) && !match;
  assign expected  = prev_inc;

  // Sequence FSM: acquire a run of good increments, then police the sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      prev   <= '0;
      run    <= '0;
      locked <= 1'b0;
      error  <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      error <= 1'b0;
      wrap  <= 1'b0;
      if (in_valid) begin
        prev <= count_in;
        unique case (state)
          IDLE: begin
            run   <= '0;
            state <= ACQUIRE;
          end
          ACQUIRE: begin
            if (match) begin
              run <= run_inc;
              if (run_inc == 4'(LOCK_COUNT)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              run <= '0;
            end
          end
          LOCKED: begin
            if (match) begin
              wrap <= &prev;
            end else begin
              error  <= 1'b1;
              run    <= '0;
              state  <= ACQUIRE;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating error count; a clear that lands on a new error leaves it at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= break_det ? ERR_W'(1) : '0;
    end else if (break_det) begin
      err_count <= sat_inc(err_count);
    end
  end

endmodule

// File: tb/tb_counter_sequence_checker.sv
// Bench for counter_sequence_checker: two instances (8-bit and 2-bit error
// counters) share one directed stimulus stream; a streak-based model predicts
// every output and is compared each cycle, with literal spot checks on top.
module tb_counter_sequence_checker;

  localparam int LC = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] count_in = '0;
  logic       err_clr = 1'b0;

  logic       locked_a, error_a, wrap_a;
  logic [7:0] errc_a;
  logic [3:0] exp_a;
  logic       locked_b, error_b, wrap_b;
  logic [1:0] errc_b;
  logic [3:0] exp_b;

  int passed = 0;
  int total  = 0;

  counter_sequence_checker #(.WIDTH(4), .LOCK_COUNT(LC), .ERR_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .count_in(count_in),
    .err_clr(err_clr), .locked(locked_a), .error(error_a), .wrap(wrap_a),
    .err_count(errc_a), .expected(exp_a)
  );

  counter_sequence_checker #(.WIDTH(4), .LOCK_COUNT(LC), .ERR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .count_in(count_in),
    .err_clr(err_clr), .locked(locked_b), .error(error_b), .wrap(wrap_b),
    .err_count(errc_b), .expected(exp_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
  endtask

  // Model: a streak of consecutive +1 steps since the last break decides lock.
  bit have_prev;
  int last_v;
  int streak;
  bit m_err, m_wrap;
  int m_cnt_a, m_cnt_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_prev = 0; last_v = 0; streak = 0;
      m_err = 0; m_wrap = 0; m_cnt_a = 0; m_cnt_b = 0;
    end else begin
      bit e;
      e = 0;
      m_wrap = 0;
      if (in_valid) begin
        if (!have_prev) begin
          have_prev = 1;
          streak = 0;
        end else begin
          bit was_locked;
          was_locked = (streak >= LC);
          if (int'(count_in) == (last_v + 1) % 16) begin
            streak++;
            if (was_locked && last_v == 15) m_wrap = 1;
          end else begin
            if (was_locked) e = 1;
            streak = 0;
          end
        end
        last_v = int'(count_in);
      end
      m_err = e;
      if (err_clr) begin
        m_cnt_a = e ? 1 : 0;
        m_cnt_b = e ? 1 : 0;
      end else if (e) begin
        if (m_cnt_a < 255) m_cnt_a++;
        if (m_cnt_b < 3) m_cnt_b++;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("locked_a", locked_a, (streak >= LC) ? 1 : 0);
      check("locked_b", locked_b, (streak >= LC) ? 1 : 0);
      check("error_a", error_a, m_err);
      check("error_b", error_b, m_err);
      check("wrap_a", wrap_a, m_wrap);
      check("wrap_b", wrap_b, m_wrap);
      check("errc_a", errc_a, m_cnt_a);
      check("errc_b", errc_b, m_cnt_b);
      check("expected_a", exp_a, (last_v + 1) % 16);
      check("expected_b", exp_b, (last_v + 1) % 16);
    end
  end

  task automatic smp(input int c, input bit clr = 1'b0);
    in_valid = 1'b1;
    count_in = 4'(c);
    err_clr  = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic gap(input int n, input int c);
    in_valid = 1'b0;
    count_in = 4'(c);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", locked_a, 0);
    check("rst_errc", errc_a, 0);
    check("rst_expected", exp_a, 1);
    rst_n = 1'b1;
    gap(1, 0);

    // Acquire: lock after the 4th valid sample.
    smp(0); smp(1); smp(2);
    check("lock_not_yet", locked_a, 0);
    smp(3);
    check("lock_4th", locked_a, 1);

    // Count through the wrap point.
    for (int v = 4; v <= 15; v++) smp(v);
    check("wrap_before", wrap_a, 0);
    smp(0);
    check("wrap_pulse", wrap_a, 1);
    smp(1);
    check("wrap_once", wrap_a, 0);
    for (int v = 2; v <= 5; v++) smp(v);

    // Break at 9, relock after 12.
    smp(9);
    check("brk_error", error_a, 1);
    check("brk_errc", errc_a, 1);
    check("brk_unlock", locked_a, 0);
    smp(10); smp(11);
    check("relock_not_yet", locked_a, 0);
    smp(12);
    check("relock", locked_a, 1);
    check("relock_expected", exp_a, 13);

    // A gap with junk on count_in keeps lock; next sample compares to prev.
    gap(5, 7);
    smp(13);
    check("gap_no_error", error_a, 0);
    check("gap_locked", locked_a, 1);

    // Repeated breaks: 2-bit counter saturates at 3.
    smp(0);
    check("brk2_errc", errc_a, 2);
    smp(1); smp(2); smp(3); smp(8);
    check("brk3_errc_b", errc_b, 3);
    smp(9); smp(10); smp(11); smp(0);
    check("sat_errc_b", errc_b, 3);
    check("nosat_errc_a", errc_a, 4);

    // Clear coincident with a break leaves one error counted.
    smp(1); smp(2); smp(3); smp(8, 1'b1);
    check("clr_err_a", errc_a, 1);
    check("clr_err_b", errc_b, 1);
    smp(9); smp(10); smp(11); smp(0);
    smp(1); smp(2); smp(3);
    check("pre_rst_errc", errc_a, 2);
    check("pre_rst_locked", locked_a, 1);

    // Asynchronous reset mid-cycle while locked.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_locked", locked_a, 0);
    check("arst_errc", errc_a, 0);
    check("arst_expected", exp_a, 1);
    check("arst_error", error_a, 0);
    check("arst_wrap", wrap_a, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    smp(6); smp(7); smp(8);
    check("post_rst_not_yet", locked_a, 0);
    smp(9);
    check("post_rst_lock", locked_a, 1);
    check("post_rst_expected", exp_a, 10);
    gap(2, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
